// File: rtl/interrupt_controller.sv
// Arbitrates frame ticks and buffered key codes into a 2-bit interrupt request,
// with a present/acknowledge/end handshake and sticky error flags.
`timescale 1ns/1ps
module interrupt_controller #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       VSYNC,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY_CODE,
  output logic [1:0] INT_IRQ,
  input  logic       INT_IACK,
  input  logic       INT_IEND,
  output logic [7:0] KBD_KEY,
  output logic       FRAME_MISSED,
  output logic       KEY_OVERRUN,
  output logic       SVC_TIMEOUT
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  logic [1:0]    state;
  logic          code;
  logic          vsync_d;
  logic          frame_pend;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   tmo_cnt;

  logic vs_edge;
  logic fifo_empty;
  logic fifo_full;
  logic frame_clr;
  logic pop;
  logic push;

  assign vs_edge    = VSYNC & ~vsync_d;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign frame_clr  = (state == ST_PRESENT) && INT_IACK && !code;
  assign pop        = (state == ST_PRESENT) && INT_IACK && code && !fifo_empty;
  // A full FIFO still accepts a key when the head leaves in the same cycle.
  assign push       = KEY_VALID && (!fifo_full || pop);

  assign INT_IRQ = (state == ST_PRESENT) ? {1'b0, code} : 2'b11;
  assign KBD_KEY = fifo_empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= KEY_CODE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      code         <= 1'b0;
      vsync_d      <= 1'b0;
      frame_pend   <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      tmo_cnt      <= '0;
      FRAME_MISSED <= 1'b0;
      KEY_OVERRUN  <= 1'b0;
      SVC_TIMEOUT  <= 1'b0;
    end else begin
      vsync_d <= VSYNC;

      // A new edge wins over the acknowledge clear: that frame is still owed.
      if (vs_edge)        frame_pend <= 1'b1;
      else if (frame_clr) frame_pend <= 1'b0;
      if (vs_edge && frame_pend && !frame_clr) FRAME_MISSED <= 1'b1;

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (KEY_VALID && !push) KEY_OVERRUN <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (frame_pend) begin
            code  <= 1'b0;
            state <= ST_PRESENT;
          end else if (!fifo_empty) begin
            code  <= 1'b1;
            state <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (INT_IACK) begin
            tmo_cnt <= '0;
            state   <= INT_IEND ? ST_IDLE : ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (INT_IEND) begin
            state <= ST_IDLE;
          end else if (tmo_cnt == TIMEOUT - 16'd1) begin
            SVC_TIMEOUT <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
